// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch FIFO between synchronous imem and IF/ID, with credit-based fetch and redirect flush.
// Optional `define PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module fetch_prefetch_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 8,
   parameter int INST_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_addr,
   output logic [INST_W-1:0] inst_out,
   output logic [PC_W-1:0]   inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   issue_pc_q, issue_pc_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PC_W-1:0]   pc_mem_q   [DEPTH];

   logic credit_ok, rsp_vld, fifo_empty, push, pop;

   // A read is only issued when a slot is already reserved for its response.
   always_comb begin
      credit_ok  = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
      imem_req   = reset & ~redirect & credit_ok;
      imem_addr  = pc_q;
      rsp_vld    = inflight_q & ~redirect;
      fifo_empty = (count_q == '0);
      pop        = ~fifo_empty & inst_ready & ~redirect;
      inst_valid = ~fifo_empty;
      inst_out   = fifo_empty ? '0 : inst_mem_q[head_q];
      inst_pc    = fifo_empty ? '0 : pc_mem_q[head_q];
`ifdef PREFETCH_BYPASS_EN
      push = rsp_vld & ~(fifo_empty & inst_ready);
      if (fifo_empty && rsp_vld) begin
         inst_valid = 1'b1;
         inst_out   = imem_rdata;
         inst_pc    = issue_pc_q;
      end
`else
      push = rsp_vld;
`endif
   end

   always_comb begin
      pc_d       = pc_q;
      issue_pc_d = issue_pc_q;
      inflight_d = 1'b0;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (redirect) begin
         pc_d    = redirect_addr;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (imem_req) begin
            pc_d       = pc_q + PC_W'(1);
            issue_pc_d = pc_q;
            inflight_d = 1'b1;
         end
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= '0;
         issue_pc_q <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Entry storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[tail_q] <= imem_rdata;
         pc_mem_q[tail_q]   <= issue_pc_q;
      end
   end

endmodule
